// File: rtl/mont16_pkg.sv
// rtl/mont16_pkg.sv - Montgomery constants, engine states and the REDC helper for M = 65521, R = 2^16
package mont16_pkg;

    localparam logic [15:0] M        = 16'd65521;
    localparam logic [15:0] M_PRIME  = 16'd61167;
    localparam logic [15:0] R_MOD_M  = 16'd15;
    localparam logic [15:0] R2_MOD_M = 16'd225;

    typedef enum logic [2:0] {
        IDLE,
        TO_MONT,
        SQ,
        MUL,
        FROM_MONT,
        DONE
    } state_e;

    // x*y*R^-1 mod M for x, y < M; the sum needs 33 bits before the shift.
    function automatic logic [15:0] mont_redc(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] t;
        logic [15:0] m;
        logic [32:0] s;
        logic [16:0] u;
        t = {16'd0, x} * {16'd0, y};
        m = t[15:0] * M_PRIME;
        s = {1'b0, t} + ({17'd0, m} * {17'd0, M});
        u = 17'(s >> 16);
        return (u >= {1'b0, M}) ? 16'(u - {1'b0, M}) : u[15:0];
    endfunction

endpackage

// File: rtl/mont_mul16_core.sv
// rtl/mont_mul16_core.sv - fully pipelined 16-bit Montgomery multiplier with fixed latency MUL_LAT
module mont_mul16_core #(
    parameter int MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic        res_valid,
    output logic [15:0] res
);
    import mont16_pkg::*;

    logic [MUL_LAT-1:0] vld_q, vld_d;
    logic [15:0]        dat_q [MUL_LAT];
    logic [15:0]        dat_d [MUL_LAT];

    always_comb begin
        vld_d    = '0;
        dat_d    = dat_q;
        vld_d[0] = op_valid;
        dat_d[0] = op_valid ? mont_redc(x, y) : 16'd0;
        for (int i = 1; i < MUL_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                dat_q[i] <= 16'd0;
            end
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign res_valid = vld_q[MUL_LAT-1];
    assign res       = dat_q[MUL_LAT-1];

endmodule

// File: rtl/mod_exp16.sv
// rtl/mod_exp16.sv - constant-time base^exp mod 65521 sequencer driving one Montgomery multiplier
module mod_exp16 #(
    parameter int MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] base,
    input  logic [15:0] exp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        busy
);
    import mont16_pkg::*;

    state_e      state_q, state_d;
    logic [15:0] e_q, e_d;
    logic [15:0] xr_q, xr_d;
    logic [15:0] xm_q, xm_d;
    logic [15:0] acc_q, acc_d;
    logic [3:0]  bit_q, bit_d;
    logic        pend_q, pend_d;
    logic [15:0] result_q, result_d;

    logic        mul_op_valid;
    logic [15:0] mul_x, mul_y;
    logic        mul_res_valid;
    logic [15:0] mul_res;

    mont_mul16_core #(
        .MUL_LAT (MUL_LAT)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (mul_op_valid),
        .x         (mul_x),
        .y         (mul_y),
        .res_valid (mul_res_valid),
        .res       (mul_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            e_q      <= 16'd0;
            xr_q     <= 16'd0;
            xm_q     <= 16'd0;
            acc_q    <= 16'd0;
            bit_q    <= 4'd0;
            pend_q   <= 1'b0;
            result_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            e_q      <= e_d;
            xr_q     <= xr_d;
            xm_q     <= xm_d;
            acc_q    <= acc_d;
            bit_q    <= bit_d;
            pend_q   <= pend_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        e_d      = e_q;
        xr_d     = xr_q;
        xm_d     = xm_q;
        acc_d    = acc_q;
        bit_d    = bit_q;
        pend_d   = pend_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    e_d     = exp;
                    xr_d    = (base >= M) ? base - M : base;
                    acc_d   = R_MOD_M;
                    bit_d   = 4'd15;
                    pend_d  = 1'b0;
                    state_d = TO_MONT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                // pend_q marks the single outstanding multiply of the current state
                if (!pend_q) begin
                    pend_d = 1'b1;
                end else if (mul_res_valid) begin
                    pend_d = 1'b0;
                    case (state_q)
                        TO_MONT: begin
                            xm_d    = mul_res;
                            state_d = SQ;
                        end
                        SQ: begin
                            acc_d   = mul_res;
                            state_d = MUL;
                        end
                        MUL: begin
                            // multiply always runs; only the write-back depends on the bit
                            if (e_q[bit_q]) begin
                                acc_d = mul_res;
                            end
                            if (bit_q == 4'd0) begin
                                state_d = FROM_MONT;
                            end else begin
                                bit_d   = bit_q - 4'd1;
                                state_d = SQ;
                            end
                        end
                        FROM_MONT: begin
                            acc_d    = mul_res;
                            result_d = mul_res;
                            state_d  = DONE;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        in_ready     = (state_q == IDLE);
        out_valid    = (state_q == DONE);
        busy         = (state_q != IDLE);
        mul_x        = 16'd0;
        mul_y        = 16'd0;
        case (state_q)
            TO_MONT: begin
                mul_x = xr_q;
                mul_y = R2_MOD_M;
            end
            SQ: begin
                mul_x = acc_q;
                mul_y = acc_q;
            end
            MUL: begin
                mul_x = acc_q;
                mul_y = xm_q;
            end
            FROM_MONT: begin
                mul_x = acc_q;
                mul_y = 16'd1;
            end
            default: ;
        endcase
        mul_op_valid = busy && (state_q != DONE) && !pend_q;
    end

    assign result = result_q;

endmodule
